// File: rtl/data_router_pkg.sv
// Shared types and widths for the data router sequencer (data_router_ctrl, dr_addr_gen).
package data_router_pkg;

  localparam int unsigned BANKW = 8;
  localparam int unsigned ROWW  = 8;
  localparam int unsigned COLW  = 28;

  typedef enum logic [1:0] {
    RR = 2'b00,
    BR = 2'b01,
    RP = 2'b10,
    NE = 2'b11
  } rpsel_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_WAIT_BLK = 2'b01,
    S_ISSUE    = 2'b10,
    S_DONE     = 2'b11
  } ctrl_state_e;

  // Router address payload presented alongside rpsel
  typedef struct packed {
    logic [BANKW-1:0] bank;
    logic [ROWW-1:0]  row;
    logic [COLW-1:0]  col;
  } rtr_addr_t;

  // Counter width for a 0..n-1 range; never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dr_addr_gen.sv
// Nested bank/row/col counters walking one router block in the selected rpsel mode.
module dr_addr_gen
  import data_router_pkg::*;
#(
  parameter int unsigned POY    = 3,
  parameter int unsigned BUFH   = 3,
  parameter int unsigned BUFW   = 32,
  parameter int unsigned KSIZE  = 3,
  parameter int unsigned STRIDE = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  rpsel_e    mode,
  input  logic      step,
  input  logic      clr,
  output rtr_addr_t addr,
  output logic      last
);

  localparam int unsigned BW = cnt_w(POY);
  localparam int unsigned RW = cnt_w(BUFH);
  localparam int unsigned CW = cnt_w(BUFW);

  localparam logic [BW-1:0] BANK_MAX   = BW'(POY - 1);
  localparam logic [RW-1:0] ROW_MAX    = RW'(BUFH - 1);
  localparam logic [RW-1:0] ROW_MAX_RR = RW'(KSIZE - 1);

  logic [BW-1:0] bank_q, bank_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          row_last;
  logic          col_last;

  // End-of-range detection and next counter values
  always_comb begin
    bank_d   = bank_q;
    row_d    = row_q;
    col_d    = col_q;
    row_last = (mode == RR) ? (row_q == ROW_MAX_RR) : (row_q == ROW_MAX);
    col_last = (32'(col_q) + STRIDE) >= BUFW;
    case (mode)
      BR:      last = row_last && (bank_q == BANK_MAX);
      RP:      last = row_last && col_last;
      default: last = row_last;
    endcase

    if (clr || (step && last)) begin
      bank_d = '0;
      row_d  = '0;
      col_d  = '0;
    end else if (step) begin
      case (mode)
        BR: begin
          if (row_last) begin
            row_d  = '0;
            bank_d = bank_q + BW'(1);
          end else begin
            row_d = row_q + RW'(1);
          end
        end
        RP: begin
          if (col_last) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = CW'(32'(col_q) + STRIDE);
          end
        end
        default: row_d = row_q + RW'(1);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      bank_q <= bank_d;
      row_q  <= row_d;
      col_q  <= col_d;
    end
  end

  assign addr.bank = BANKW'(bank_q);
  assign addr.row  = ROWW'(row_q);
  assign addr.col  = COLW'(col_q);

endmodule

// File: rtl/data_router_ctrl.sv
// Data router sequencer: waits for buffer blocks and walks router windows to the PE array.
// Optional perf counters built when DATA_ROUTER_PERF_EN is defined.
module data_router_ctrl
  import data_router_pkg::*;
#(
  parameter int unsigned POY    = 3,
  parameter int unsigned BUFH   = 3,
  parameter int unsigned BUFW   = 32,
  parameter int unsigned KSIZE  = 3,
  parameter int unsigned STRIDE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       cfg_mode,
  input  logic [15:0]      cfg_nblk,
  input  logic             blkend,
  input  logic             pe_ready,
  output logic [BANKW-1:0] bank,
  output logic [ROWW-1:0]  row,
  output logic [COLW-1:0]  col,
  output logic [1:0]       rpsel,
  output logic             data_vld,
  output logic             blk_done,
  output logic             layer_done,
  output logic             busy,
  output logic             err_ovf,
  output logic [31:0]      perf_stall,
  output logic [31:0]      perf_beats
);

  ctrl_state_e state_q, state_d;
  rpsel_e      mode_q;
  rpsel_e      rpsel_q;
  logic [15:0] nblk_q;
  logic [15:0] blk_cnt_q;
  logic        pend_q;
  logic        err_q;
  logic        data_vld_q;
  logic        layer_done_q;
  logic        busy_q;
  logic        beat;
  logic        start_acc;
  logic        ag_last;
  rtr_addr_t   ag_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, beat qualification and last-beat pulse
  always_comb begin
    state_d   = state_q;
    beat      = 1'b0;
    start_acc = 1'b0;
    blk_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = (cfg_nblk == 16'd0) ? S_DONE : S_WAIT_BLK;
        end
      end
      S_WAIT_BLK: begin
        if (blkend || pend_q) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (pe_ready) begin
          beat = 1'b1;
          if (ag_last) begin
            blk_done = 1'b1;
            state_d  = (blk_cnt_q == nblk_q - 16'd1) ? S_DONE : S_WAIT_BLK;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Layer configuration and block count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= RR;
      nblk_q    <= '0;
      blk_cnt_q <= '0;
    end else begin
      if (start_acc) begin
        mode_q    <= (cfg_mode == 2'b11) ? RR : rpsel_e'(cfg_mode);
        nblk_q    <= cfg_nblk;
        blk_cnt_q <= '0;
      end else if (blk_done) begin
        blk_cnt_q <= blk_cnt_q + 16'd1;
      end
    end
  end

  // A blkend seen in WAIT_BLK is consumed by the transition; elsewhere it is queued once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == S_WAIT_BLK) begin
        pend_q <= blkend && pend_q;
      end else if (blkend) begin
        pend_q <= 1'b1;
        if (pend_q) err_q <= 1'b1;
      end
      if (start_acc && (cfg_mode == 2'b11)) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_vld_q   <= 1'b0;
      layer_done_q <= 1'b0;
      busy_q       <= 1'b0;
      rpsel_q      <= RR;
    end else begin
      data_vld_q   <= beat;
      layer_done_q <= (state_d == S_DONE);
      busy_q       <= (state_d != S_IDLE);
      rpsel_q      <= (state_d == S_ISSUE) ? mode_q : RR;
    end
  end

  // Counters idle at zero outside ISSUE, so the addresses read zero there
  dr_addr_gen #(
    .POY    (POY),
    .BUFH   (BUFH),
    .BUFW   (BUFW),
    .KSIZE  (KSIZE),
    .STRIDE (STRIDE)
  ) u_addr_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode_q),
    .step  (beat),
    .clr   (state_q != S_ISSUE),
    .addr  (ag_addr),
    .last  (ag_last)
  );

  assign bank       = ag_addr.bank;
  assign row        = ag_addr.row;
  assign col        = ag_addr.col;
  assign rpsel      = rpsel_q;
  assign data_vld   = data_vld_q;
  assign layer_done = layer_done_q;
  assign busy       = busy_q;
  assign err_ovf    = err_q;

`ifdef DATA_ROUTER_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] beats_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      beats_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
      beats_q <= '0;
    end else begin
      if ((state_q == S_ISSUE) && !pe_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (beat && (beats_q != '1)) beats_q <= beats_q + 32'd1;
    end
  end

  assign perf_stall = stall_q;
  assign perf_beats = beats_q;
`else
  assign perf_stall = '0;
  assign perf_beats = '0;
`endif

endmodule
